// File: rtl/semaphore_pkg.sv
// ============================================================================
// Module  : semaphore_pkg
// Purpose : Shared words, reply bit positions and enums of the semaphore
//           word protocol.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package semaphore_pkg;

    localparam logic [15:0] START_BASE = 16'hFD04;
    localparam logic [15:0] STOP       = 16'hFDFF;
    localparam logic [15:0] OP_POST    = 16'h0D10;
    localparam logic [15:0] OP_WAIT    = 16'h0D20;
    localparam logic [7:0]  ID_NODE0   = 8'h01;
    localparam logic [7:0]  ID_NODE1   = 8'h02;
    localparam int          FULL_BIT   = 12;
    localparam int          EMPTY_BIT  = 13;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_FULL    = 2'b01,
        ST_EMPTY   = 2'b10,
        ST_TIMEOUT = 2'b11
    } status_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_OP    = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // A zero priority would encode the same start word as no request at all.
    function automatic logic [3:0] clamp_prio(input logic [3:0] prio);
        return (prio == 4'd0) ? 4'd1 : prio;
    endfunction

endpackage

`default_nettype wire

// File: rtl/semaphore_client_if.sv
// ============================================================================
// Module  : semaphore_client_if
// Purpose : Request/completion handshake plus responder word pair of one
//           semaphore client node.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface semaphore_client_if;
    import semaphore_pkg::*;

    logic        req;
    logic        req_op;
    logic [3:0]  req_prio;
    logic        busy;
    logic        done;
    status_t     status;
    logic [15:0] op_out;
    logic [15:0] in_resp;

    modport master (
        output req, req_op, req_prio, in_resp,
        input  busy, done, status, op_out
    );

    modport slave (
        input  req, req_op, req_prio, in_resp,
        output busy, done, status, op_out
    );

endinterface

`default_nettype wire

// File: rtl/semaphore_client.sv
// ============================================================================
// Module  : semaphore_client
// Purpose : Single-node initiator running start/op/response/stop sequences
//           against the counting-semaphore responder, with bounded retry.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module semaphore_client
    import semaphore_pkg::*;
#(
    parameter int NODE_ID   = 0,
    parameter int MAX_RETRY = 15
) (
    input  wire logic CLK,
    input  wire logic RST,
    semaphore_client_if.slave bus
);

    localparam int              RETRY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [7:0]      ID_CODE   = (NODE_ID == 0) ? ID_NODE0 : ID_NODE1;

    state_t               state_q,  state_d;
    logic [15:0]          op_out_q, op_out_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;
    status_t              status_q, status_d;
    logic [RETRY_W-1:0]   retry_q,  retry_d;
    logic                 op_sel_q, op_sel_d;
    logic [3:0]           prio_q,   prio_d;

    logic [15:0]          w_op_word;
    logic [15:0]          w_start_word;
    logic                 w_match;

    assign w_op_word    = op_sel_q ? OP_WAIT : OP_POST;
    assign w_start_word = START_BASE ^ {12'h000, prio_q};

    // A reply with 11 in the top bits is a different word class even if the low bits match.
    assign w_match = (bus.in_resp[7:0] == ID_CODE) &&
                     (bus.in_resp[11:8] == 4'hD) &&
                     (bus.in_resp[15:14] != 2'b11);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            op_out_q <= STOP;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            status_q <= ST_OK;
            retry_q  <= '0;
            op_sel_q <= 1'b0;
            prio_q   <= 4'd1;
        end else begin
            state_q  <= state_d;
            op_out_q <= op_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            status_q <= status_d;
            retry_q  <= retry_d;
            op_sel_q <= op_sel_d;
            prio_q   <= prio_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_out_d = op_out_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        status_d = status_q;
        retry_d  = retry_q;
        op_sel_d = op_sel_q;
        prio_d   = prio_q;

        case (state_q)
            S_IDLE: begin
                op_out_d = STOP;
                if (bus.req) begin
                    op_sel_d = bus.req_op;
                    prio_d   = clamp_prio(bus.req_prio);
                    busy_d   = 1'b1;
                    retry_d  = '0;
                    op_out_d = START_BASE ^ {12'h000, clamp_prio(bus.req_prio)};
                    state_d  = S_START;
                end
            end
            S_START: begin
                op_out_d = w_op_word;
                state_d  = S_OP;
            end
            // Falling back to the start word keeps the lock without re-issuing the op.
            S_OP: begin
                op_out_d = w_start_word;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (w_match) begin
                    if (bus.in_resp[EMPTY_BIT]) begin
                        status_d = ST_EMPTY;
                    end else if (bus.in_resp[FULL_BIT]) begin
                        status_d = ST_FULL;
                    end else begin
                        status_d = ST_OK;
                    end
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    op_out_d = STOP;
                    state_d  = S_IDLE;
                end else if (retry_q != RETRY_MAX) begin
                    retry_d  = retry_q + RETRY_W'(1);
                    op_out_d = w_op_word;
                    state_d  = S_OP;
                end else begin
                    status_d = ST_TIMEOUT;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    op_out_d = STOP;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                op_out_d = STOP;
                state_d  = S_IDLE;
            end
        endcase
    end

    assign bus.op_out = op_out_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.status = status_q;

endmodule

`default_nettype wire

// File: tb/tb_semaphore_client.sv
// ============================================================================
// Module  : tb_semaphore_client
// Purpose : Two-node environment with a behavioural counting-semaphore
//           responder; scenario tasks check clients against a coin model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_semaphore_client;
    import semaphore_pkg::*;

    localparam int CAP = 10;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic resp_rst = 1'b1;
    always #5 CLK = ~CLK;

    semaphore_client_if if0 ();
    semaphore_client_if if1 ();
    semaphore_client_if if2 ();

    semaphore_client #(.NODE_ID(0), .MAX_RETRY(15)) u_c0 (.CLK(CLK), .RST(RST), .bus(if0.slave));
    semaphore_client #(.NODE_ID(1), .MAX_RETRY(15)) u_c1 (.CLK(CLK), .RST(RST), .bus(if1.slave));
    semaphore_client #(.NODE_ID(0), .MAX_RETRY(2))  u_c2 (.CLK(CLK), .RST(RST), .bus(if2.slave));

    int checks = 0;
    int errors = 0;
    int model_coins = 0;

    // Responder environment: node 0 slot is shared by c0/c2, node 1 slot may be pinned locked.
    logic [15:0] resp_q;
    int          coins;
    int          owner;
    logic        sel_c2 = 1'b0;
    logic        hold_lock = 1'b0;
    logic [15:0] n0_word, n1_word;

    assign n0_word = sel_c2 ? if2.op_out : if0.op_out;
    assign n1_word = hold_lock ? 16'hFD0B : if1.op_out;
    assign if0.in_resp = resp_q;
    assign if1.in_resp = resp_q;
    assign if2.in_resp = resp_q;

    function automatic bit is_start(input logic [15:0] w);
        return (w[15:4] == 12'hFD0) && (w[3:0] != 4'h4);
    endfunction

    function automatic int start_prio(input logic [15:0] w);
        return int'(w[3:0] ^ 4'h4);
    endfunction

    always @(posedge CLK) begin : p_responder
        logic [15:0] cur;
        logic [15:0] r;
        int          nxt;
        int          best;
        if (resp_rst) begin
            resp_q <= 16'h0000;
            coins  <= 0;
            owner  <= -1;
        end else begin
            r   = 16'h0000;
            nxt = owner;
            if (owner >= 0) begin
                cur = (owner == 0) ? n0_word : n1_word;
                if (cur == OP_POST || cur == OP_WAIT) begin
                    r = {8'h0D, (owner == 0) ? 8'h01 : 8'h02};
                    if (cur == OP_POST) begin
                        if (coins == CAP) r[12] = 1'b1;
                        else coins <= coins + 1;
                    end else begin
                        if (coins == 0) r[13] = 1'b1;
                        else coins <= coins - 1;
                    end
                end
                if (cur == STOP) nxt = -1;
            end
            if (nxt < 0) begin
                best = 0;
                if (is_start(n0_word)) begin
                    nxt  = 0;
                    best = start_prio(n0_word);
                end
                if (is_start(n1_word) && start_prio(n1_word) > best) nxt = 1;
            end
            owner  <= nxt;
            resp_q <= r;
        end
    end

    logic [15:0] seq_q[$];
    logic [15:0] last_resp;
    logic        busy_c1;

    // Runs one c0 transaction; lat is the cycle (1 = first after accept) in which done is seen.
    task automatic do_txn(input logic op, input logic [3:0] prio, output int lat, output logic [1:0] st);
        seq_q.delete();
        lat = 0;
        st  = 2'b00;
        @(negedge CLK);
        if0.req = 1'b1; if0.req_op = op; if0.req_prio = prio;
        @(negedge CLK);
        busy_c1 = if0.busy;
        if0.req = 1'b0; if0.req_op = 1'($urandom); if0.req_prio = 4'($urandom);
        for (int n = 1; n <= 100; n++) begin
            if (n > 1) @(negedge CLK);
            seq_q.push_back(if0.op_out);
            if (if0.done) begin
                lat = n;
                st  = if0.status;
                break;
            end
            last_resp = if0.in_resp;
        end
        checks++;
        if (lat == 0) begin
            errors++;
            $display("FAIL txn_done_timeout: no done within 100 cycles, required done");
        end
    endtask

    function automatic logic [1:0] model_op(input logic op);
        logic [1:0] s;
        if (op == 1'b0) begin
            if (model_coins == CAP) s = ST_FULL;
            else begin s = ST_OK; model_coins++; end
        end else begin
            if (model_coins == 0) s = ST_EMPTY;
            else begin s = ST_OK; model_coins--; end
        end
        return s;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        checks++; if (if0.op_out !== 16'hFDFF) begin errors++; $display("FAIL reset_op_out: got %h want FDFF", if0.op_out); end
        checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", if0.busy); end
        checks++; if (if0.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", if0.done); end
        checks++; if (if0.status !== 2'b00) begin errors++; $display("FAIL reset_status: got %b want 00", if0.status); end
        RST = 1'b0; resp_rst = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_basic_post();
        int lat; logic [1:0] st; logic [1:0] exp;
        exp = model_op(1'b0);
        do_txn(1'b0, 4'd5, lat, st);
        checks++; if (seq_q.size() != 4 || seq_q[0] !== 16'hFD01 || seq_q[1] !== 16'h0D10 || seq_q[2] !== 16'hFD01 || seq_q[3] !== 16'hFDFF) begin
            errors++; $display("FAIL post_sequence: got %p want FD01 0D10 FD01 FDFF", seq_q); end
        checks++; if (lat != 4) begin errors++; $display("FAIL post_latency: got %0d want 4", lat); end
        checks++; if (st !== exp) begin errors++; $display("FAIL post_status: got %b want %b", st, exp); end
        checks++; if (busy_c1 !== 1'b1) begin errors++; $display("FAIL post_busy: got %b want 1", busy_c1); end
        checks++; if (coins != model_coins) begin errors++; $display("FAIL post_coins: got %0d want %0d", coins, model_coins); end
    endtask

    task automatic test_clamp_wait();
        int lat; logic [1:0] st; logic [1:0] exp;
        exp = model_op(1'b1);
        do_txn(1'b1, 4'd0, lat, st);
        checks++; if (seq_q[0] !== 16'hFD05 || seq_q[1] !== 16'h0D20) begin
            errors++; $display("FAIL clamp_words: got %h %h want FD05 0D20", seq_q[0], seq_q[1]); end
        checks++; if (st !== exp) begin errors++; $display("FAIL clamp_status: got %b want %b", st, exp); end
        checks++; if (coins != model_coins) begin errors++; $display("FAIL clamp_coins: got %0d want %0d", coins, model_coins); end
    endtask

    task automatic test_empty();
        int lat; logic [1:0] st; int ops;
        do_txn(1'b1, 4'd4, lat, st);
        ops = 0;
        foreach (seq_q[i]) if (seq_q[i] == OP_WAIT) ops++;
        checks++; if (st !== 2'b10) begin errors++; $display("FAIL empty_status: got %b want 10", st); end
        checks++; if (last_resp !== 16'h2D01) begin errors++; $display("FAIL empty_reply: got %h want 2D01", last_resp); end
        checks++; if (ops != 1 || lat != 4) begin errors++; $display("FAIL empty_op_cycles: got ops=%0d lat=%0d want 1/4", ops, lat); end
        checks++; if (coins != 0) begin errors++; $display("FAIL empty_coins: got %0d want 0", coins); end
    endtask

    task automatic test_full();
        int lat; logic [1:0] st; logic [1:0] exp;
        for (int i = 0; i < CAP; i++) begin
            exp = model_op(1'b0);
            do_txn(1'b0, 4'($urandom_range(1, 15)), lat, st);
            checks++; if (st !== exp) begin errors++; $display("FAIL fill_status[%0d]: got %b want %b", i, st, exp); end
        end
        do_txn(1'b0, 4'd7, lat, st);
        checks++; if (st !== 2'b01) begin errors++; $display("FAIL full_status: got %b want 01", st); end
        checks++; if (last_resp !== 16'h1D01) begin errors++; $display("FAIL full_reply: got %h want 1D01", last_resp); end
        checks++; if (coins != CAP) begin errors++; $display("FAIL full_coins: got %0d want %0d", coins, CAP); end
    endtask

    task automatic test_random();
        int lat; logic [1:0] st; logic [1:0] exp; logic op;
        for (int i = 0; i < 30; i++) begin
            op  = 1'($urandom);
            exp = model_op(op);
            do_txn(op, 4'($urandom), lat, st);
            checks++; if (st !== exp || lat != 4) begin
                errors++; $display("FAIL rand_txn[%0d]: got status %b lat %0d want %b lat 4", i, st, lat, exp); end
            checks++; if (coins != model_coins) begin errors++; $display("FAIL rand_coins[%0d]: got %0d want %0d", i, coins, model_coins); end
        end
    endtask

    task automatic test_back_to_back();
        logic op; int d1, d2; logic [1:0] s1, s2, e1, e2; logic b1;
        op = (model_coins <= CAP - 2) ? 1'b0 : 1'b1;
        e1 = model_op(op); e2 = model_op(op);
        d1 = 0; d2 = 0; b1 = 1'b1; s1 = 2'b00; s2 = 2'b00;
        @(negedge CLK);
        if0.req = 1'b1; if0.req_op = op; if0.req_prio = 4'd7;
        for (int n = 1; n <= 40 && d2 == 0; n++) begin
            @(negedge CLK);
            if (if0.done) begin
                if (d1 == 0) begin d1 = n; s1 = if0.status; b1 = if0.busy; end
                else begin d2 = n; s2 = if0.status; if0.req = 1'b0; end
            end
        end
        if0.req = 1'b0;
        checks++; if (d1 != 4 || d2 != 8) begin errors++; $display("FAIL b2b_done_cycles: got %0d %0d want 4 8", d1, d2); end
        checks++; if (s1 !== e1 || s2 !== e2) begin errors++; $display("FAIL b2b_status: got %b %b want %b %b", s1, s2, e1, e2); end
        checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL b2b_busy_at_done: got %b want 0", b1); end
        checks++; if (coins != model_coins) begin errors++; $display("FAIL b2b_coins: got %0d want %0d", coins, model_coins); end
    endtask

    task automatic test_two_clients();
        logic op; int d0, d1; logic [1:0] s0, s1, e0, e1;
        op = (model_coins <= CAP - 2) ? 1'b0 : 1'b1;
        e1 = model_op(op); e0 = model_op(op);
        d0 = 0; d1 = 0; s0 = 2'b00; s1 = 2'b00;
        @(negedge CLK);
        if0.req = 1'b1; if0.req_op = op; if0.req_prio = 4'd3;
        if1.req = 1'b1; if1.req_op = op; if1.req_prio = 4'd9;
        for (int n = 1; n <= 60 && (d0 == 0 || d1 == 0); n++) begin
            @(negedge CLK);
            if0.req = 1'b0; if1.req = 1'b0;
            if (if0.done && d0 == 0) begin d0 = n; s0 = if0.status; end
            if (if1.done && d1 == 0) begin d1 = n; s1 = if1.status; end
        end
        checks++; if (d1 != 4) begin errors++; $display("FAIL two_node1_done: got %0d want 4", d1); end
        checks++; if (d0 != 8) begin errors++; $display("FAIL two_node0_done: got %0d want 8", d0); end
        checks++; if (s0 !== e0 || s1 !== e1) begin errors++; $display("FAIL two_status: got %b %b want %b %b", s0, s1, e0, e1); end
        checks++; if (coins != model_coins) begin errors++; $display("FAIL two_coins: got %0d want %0d", coins, model_coins); end
    endtask

    task automatic test_timeout();
        int d, ops; logic [1:0] st; logic [15:0] after; int c_before;
        sel_c2 = 1'b1; hold_lock = 1'b1;
        repeat (3) @(negedge CLK);
        c_before = coins;
        d = 0; ops = 0; st = 2'b00; after = 16'h0000;
        if2.req = 1'b1; if2.req_op = 1'b0; if2.req_prio = 4'd15;
        for (int n = 1; n <= 40 && d == 0; n++) begin
            @(negedge CLK);
            if2.req = 1'b0;
            if (if2.op_out == OP_POST) ops++;
            if (if2.done) begin d = n; st = if2.status; after = if2.op_out; end
        end
        checks++; if (d != 8) begin errors++; $display("FAIL timeout_done_cycle: got %0d want 8", d); end
        checks++; if (ops != 3) begin errors++; $display("FAIL timeout_op_issues: got %0d want 3", ops); end
        checks++; if (st !== 2'b11) begin errors++; $display("FAIL timeout_status: got %b want 11", st); end
        checks++; if (after !== 16'hFDFF) begin errors++; $display("FAIL timeout_op_out: got %h want FDFF", after); end
        checks++; if (coins != c_before) begin errors++; $display("FAIL timeout_coins: got %0d want %0d", coins, c_before); end
        hold_lock = 1'b0; sel_c2 = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        int lat; logic [1:0] st; logic [1:0] exp; int pulses; logic op;
        op = (model_coins == CAP) ? 1'b1 : 1'b0;
        @(negedge CLK);
        if0.req = 1'b1; if0.req_op = op; if0.req_prio = 4'd6;
        @(negedge CLK);
        if0.req = 1'b0;
        @(negedge CLK);
        checks++; if (if0.op_out !== (op ? OP_WAIT : OP_POST)) begin errors++; $display("FAIL rstmid_in_op: got %h", if0.op_out); end
        RST = 1'b1;
        #1;
        checks++; if (if0.op_out !== 16'hFDFF || if0.busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_async: got op_out %h busy %b want FDFF 0", if0.op_out, if0.busy); end
        @(negedge CLK);
        RST = 1'b0;
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge CLK);
            if (if0.done) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rstmid_done_pulse: got %0d want 0", pulses); end
        checks++; if (coins != model_coins) begin errors++; $display("FAIL rstmid_coins: got %0d want %0d", coins, model_coins); end
        exp = model_op(op);
        do_txn(op, 4'd6, lat, st);
        checks++; if (st !== exp || lat != 4) begin errors++; $display("FAIL rstmid_next_txn: got %b lat %0d want %b lat 4", st, lat, exp); end
    endtask

    initial begin
        if0.req = 1'b0; if0.req_op = 1'b0; if0.req_prio = 4'd1;
        if1.req = 1'b0; if1.req_op = 1'b0; if1.req_prio = 4'd1;
        if2.req = 1'b0; if2.req_op = 1'b0; if2.req_prio = 4'd1;
        last_resp = 16'h0000;
        busy_c1 = 1'b0;
        test_reset();
        test_basic_post();
        test_clamp_wait();
        test_empty();
        test_full();
        test_random();
        test_back_to_back();
        test_two_clients();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/semaphore_client.md
Name: semaphore_client

Overview:
- Hardware initiator for the 16-bit semaphore word protocol. The block acts as one MCU node (node 0 or node 1) toward the FPGA-side counting-semaphore responder.
- It accepts a single post or wait request from local fabric logic and runs the full sequence: start/priority word, operation word, response check with bounded retry, stop word.
- It reports completion and the result flag (ok/full/empty/timeout) to the requester.
- op_out wires to the responder's node input; in_resp wires to the responder's shared output.

Parameters:
NODE_ID, 0, node slot driven; 0 selects ack ID code 0x01, 1 selects 0x02.
MAX_RETRY, 15, number of extra op-word issues after the first before timeout; 0..255.

Ports:
CLK  in  1  clock.
RST  in  1  reset, asynchronous, active-high.
req  in  1  request strobe; sampled only in IDLE.
req_op  in  1  0 = post (0x0D10), 1 = wait (0x0D20).
req_prio  in  4  access priority 1..15; value 0 is clamped to 1.
op_out  out  16  registered word driven toward the responder.
in_resp  in  16  responder output word.
busy  out  1  high from the accepting edge until done.
done  out  1  single-cycle completion pulse.
status  out  2  valid while done=1 and held until next accept: 00 ok, 01 full, 10 empty, 11 timeout.

Behaviour:
- Protocol words:
  - START = 0xFD04 XOR prio.
  - STOP = 0xFDFF.
  - POST = 0x0D10, WAIT = 0x0D20.
- Responder reply matches this node when in_resp[7:0] equals the ID code AND in_resp[11:8]==0xD AND in_resp[15:14]!=2'b11.
  - Bit 12 of a matching reply means full.
  - Bit 13 of a matching reply means empty.
- Reset values: op_out=STOP, state IDLE, busy=0, done=0, status=00, retry counter 0.
  - STOP is harmless to an unlocked responder, so a reset never leaves a spurious lock request.
- FSM states: IDLE, START, OP, RESP.
  - IDLE: op_out=STOP. When req=1 at an edge: latch req_op and clamped prio, set busy, clear retry counter, op_out<=START, go START.
  - START, one cycle: op_out<=OP word, go OP.
  - OP, one cycle; responder processes op this cycle: op_out<=START, go RESP.
  - RESP: sample in_resp combinationally at the closing edge.
    - Match: status<=flags (bit13 gives 10, else bit12 gives 01, else 00), done<=1, busy<=0, op_out<=STOP, go IDLE.
    - No match (zero word, or a word carrying the other node's ID) and retry<MAX_RETRY: retry+1, op_out<=OP word, go OP.
    - No match and retry==MAX_RETRY: status<=11, done<=1, busy<=0, op_out<=STOP, go IDLE.
- The OP word is never driven for more than one consecutive cycle. This prevents multiple coin changes from one request.
- Uncontended latency: accepting edge E0, done high during the cycle after E3 (3 cycles). Each retry adds 2 cycles.
- Worst-case timeout: 3+2*MAX_RETRY cycles.
- A full or empty reply is a completed transaction and is not retried.
- req held high continuously: a new transaction is accepted at the first edge where the state is IDLE. The cycle after done is IDLE, so back-to-back accepts are spaced one IDLE cycle apart.
- req_op/req_prio changes while busy are ignored.
- RST mid-transaction: op_out returns to STOP immediately (async). A responder lock held by this node is released by that STOP word on the next responder edge.
- retry counter width: clog2(MAX_RETRY+1), minimum 1 bit; no wrap.

Decomposition:
- Shared package semaphore_pkg: START_BASE 0xFD04, STOP 0xFDFF, OP_POST 0x0D10, OP_WAIT 0x0D20, ID codes 0x01/0x02, FULL_BIT 12, EMPTY_BIT 13, status enum, FSM state enum.
- No RTL sub-module; single FSM.
- Bench reuses the existing semaphore responder as the DUT's counterpart.

Test Plan:
- NODE_ID=0, prio 5, post, responder empty and unlocked: op_out sequence 0xFD01, 0x0D10, 0xFD01, 0xFDFF. done in 4th cycle, status 00, responder coins 0->1.
- Wait with coins=0: reply 0x2D01 -> status 10, coins stay 0, exactly one op cycle.
- 10 posts, then an 11th: 11th reply 0x1D01 -> status 01, coins stay 10.
- Two clients (NODE_ID 0/1), simultaneous req, prios 3 and 9: node1 completes first. Node0 sees 0x0D02 or zero, retries, then completes. Final coins delta = 2.
- MAX_RETRY=2, other node holds lock permanently: node0 issues op 3 times, status 11, done after 7 cycles, op_out=0xFDFF afterwards.
- RST asserted in OP state: op_out=0xFDFF asynchronously, busy=0, done never pulses. Next req completes normally.
